// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MIPS multiply/divide unit owning HI/LO
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDUEn,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   hi_q,    hi_d;
    logic [31:0]   lo_q,    lo_d;
    logic [31:0]   phi_q,   phi_d;
    logic [31:0]   plo_q,   plo_d;

    logic [63:0] a_sext, b_sext, prod_s, prod_u;
    logic        a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_mag_safe, b_u_safe;
    logic [31:0] sq_mag, sr_mag, s_quo, s_rem, u_quo, u_rem;

    // Result datapath: products and quotients from the current operands.
    // Signed division works on magnitudes so that 0x80000000 / -1 wraps cleanly
    // and the divisor is forced to 1 when zero to keep the dividers defined.
    always_comb begin
        a_sext     = {{32{RsData[31]}}, RsData};
        b_sext     = {{32{RtData[31]}}, RtData};
        prod_s     = a_sext * b_sext;
        prod_u     = {32'd0, RsData} * {32'd0, RtData};
        div_zero   = (RtData == 32'd0);
        a_neg      = RsData[31];
        b_neg      = RtData[31];
        a_mag      = a_neg ? (~RsData + 32'd1) : RsData;
        b_mag      = b_neg ? (~RtData + 32'd1) : RtData;
        b_mag_safe = div_zero ? 32'd1 : b_mag;
        b_u_safe   = div_zero ? 32'd1 : RtData;
        sq_mag     = a_mag / b_mag_safe;
        sr_mag     = a_mag % b_mag_safe;
        s_quo      = (a_neg ^ b_neg) ? (~sq_mag + 32'd1) : sq_mag;
        s_rem      = a_neg ? (~sr_mag + 32'd1) : sr_mag;
        u_quo      = RsData / b_u_safe;
        u_rem      = RsData % b_u_safe;
    end

    // Next-state: issue/mthi/mtlo only in IDLE; RUN counts down and commits at cnt==1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        if (state_q == ST_IDLE) begin
            if (MDUEn) begin
                case (MDUOp)
                    OP_MULT: begin
                        {phi_d, plo_d} = prod_s;
                        cnt_d          = CW'(MULT_CYCLES);
                        state_d        = ST_RUN;
                    end
                    OP_MULTU: begin
                        {phi_d, plo_d} = prod_u;
                        cnt_d          = CW'(MULT_CYCLES);
                        state_d        = ST_RUN;
                    end
                    OP_DIV: begin
                        phi_d   = div_zero ? hi_q : s_rem;
                        plo_d   = div_zero ? lo_q : s_quo;
                        cnt_d   = CW'(DIV_CYCLES);
                        state_d = ST_RUN;
                    end
                    OP_DIVU: begin
                        phi_d   = div_zero ? hi_q : u_rem;
                        plo_d   = div_zero ? lo_q : u_quo;
                        cnt_d   = CW'(DIV_CYCLES);
                        state_d = ST_RUN;
                    end
                    OP_MTHI: hi_d = RsData;
                    OP_MTLO: lo_d = RsData;
                    default: ;
                endcase
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                hi_d    = phi_q;
                lo_d    = plo_q;
                state_d = ST_IDLE;
            end
        end
    end

    // State registers with asynchronous active-low clear; a reset mid-RUN drops the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in the EX stage beside the ALU. It consumes the MDU operation code issued by the EX-stage decoder, computes mult/multu/div/divu, and owns the architectural HI/LO registers. It also handles mthi/mtlo writes and exposes HI/LO for mfhi/mflo. It reports a Busy flag that the hazard unit uses to stall later MDU instructions.

## Interface
- MULT_CYCLES, 5, Busy duration for mult/multu (≥1)
- DIV_CYCLES, 10, Busy duration for div/divu (≥1)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state
- MDUEn  input  1  issue strobe for the EX-stage instruction, sampled each rising edge
- MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- RsData  input  32  operand A (dividend / multiplicand / mthi-mtlo source)
- RtData  input  32  operand B (divisor / multiplier)
- Busy  output  1  an operation is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

## Operation
- Two states: IDLE (Busy=0) and RUN (Busy=1). Internal state is a down-counter cnt of width clog2(max(MULT_CYCLES, DIV_CYCLES))+1, plus pending result registers pHI/pLO.
- Issue: an issue is MDUEn=1 with MDUOp in 1..4 while in IDLE, seen at a rising edge.
  - On issue, the result is computed from RsData/RtData and latched into pHI/pLO.
  - cnt loads MULT_CYCLES or DIV_CYCLES, and the state goes to RUN.
- RUN: cnt decrements each edge. On the edge where cnt==1, HI←pHI, LO←pLO, and the state goes to IDLE.
- mult: the signed 64-bit product goes to {HI,LO}. multu: the unsigned 64-bit product goes to {HI,LO}.
- div (signed):
  - LO = quotient truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divisor 0 (div or divu):
  - The full DIV_CYCLES Busy period still runs.
  - pHI/pLO are loaded with the current HI/LO, so HI and LO are unchanged at completion.
- mthi/mtlo: when MDUEn=1 in IDLE, HI←RsData (mthi) or LO←RsData (mtlo) at that edge. Busy stays 0.
- Any MDUEn while in RUN is ignored, including mthi/mtlo.
  - The hazard unit guarantees this never happens: it stalls on Busy, or on MDUEn with MDUOp in 1..6.
  - The bench checks that the ignore behaviour holds.
- MDUOp 0 or 7, or MDUEn=0: no state change.

## Timing
- Reset values: state IDLE, Busy=0, HI=0, LO=0, cnt=0, pHI=pLO=0. Reset is asynchronous and takes effect immediately.
- Reset asserted during RUN aborts the operation: HI and LO are cleared, not written with the result.
- Issue at edge E0:
  - Busy=1 from after E0 through edge E0+N, where N is the cycle parameter for the operation.
  - Busy=0 after E0+N.
  - HI/LO take the new values after E0+N, in the same cycle Busy falls.
  - Latency: N cycles.
- Back-to-back operations: a new issue is accepted at edge E0+N+1 at the earliest. The issue cannot coincide with the completing edge E0+N, because Busy=1 at that edge.
- mthi/mtlo: single-edge update, visible the next cycle.
- HI and LO are registered outputs and never combinational from the inputs.
- mfhi/mflo read HI/LO directly. Correctness relies on the hazard unit stalling mfhi/mflo while Busy=1.

## Test plan
- mult, RsData=0xFFFFFFFD (−3), RtData=5: Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu, 0xFFFFFFFF × 2: after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Then div, 0xFFFFFFF9 (−7) / 2, issued the cycle after Busy falls: Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Then divu, 10 / 0, with HI=0x1234, LO=0x5678 preset by mthi/mtlo: Busy for 10 cycles, and HI/LO remain 0x1234/0x5678.
- During a divu Busy period, drive MDUEn with mthi RsData=0xAAAA and with mult: both are ignored, the final result is the divu result, and Busy duration is unchanged.
- Drop reset to 0 in the 3rd Busy cycle of a mult: Busy, HI and LO are 0 immediately. After release, an mtlo of 0x55 gives LO=0x55 on the next cycle with Busy=0.
